// File: rtl/cordic_atan2_seq_if.sv
// Handshake and operand bundle for the sequential CORDIC atan2 engine.
// The requester owns start and the operands. The engine owns status and results.
interface cordic_atan2_seq_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 32
) ();
  logic                    start;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic                    busy;
  logic                    done;
  logic signed [AW-1:0]    angle;
  logic        [WIDTH+1:0] mag;

  modport master (
    output start, x_in, y_in,
    input  busy, done, angle, mag
  );

  modport slave (
    input  start, x_in, y_in,
    output busy, done, angle, mag
  );
endinterface

// File: rtl/cordic_atan2_seq.sv
// Sequential CORDIC vectoring engine: four-quadrant atan2(y, x) in degrees
// plus K-scaled magnitude, one micro-rotation per clock, start/busy/done.
module cordic_atan2_seq #(
  parameter int WIDTH = 32,
  parameter int AW    = 32,
  parameter int ITER  = 16
) (
  input  logic              clk,
  input  logic              rst,
  cordic_atan2_seq_if.slave bus
);

  localparam int XW   = WIDTH + 2;   // headroom for negation and CORDIC gain
  localparam int FRAC = AW - 10;     // angle fraction bits

  localparam logic signed [AW-1:0] Z_90 = AW'(longint'(90) <<< FRAC);

  if (ITER < 8 || ITER > 24) begin : g_iter_check
    $error("cordic_atan2_seq: ITER=%0d outside legal range 8..24", ITER);
  end

  // atan(2^-i) in degrees; rounded to the angle grid below.
  function automatic real atan_deg(input int i);
    case (i)
      0:       atan_deg = 45.0;
      1:       atan_deg = 26.56505117707799;
      2:       atan_deg = 14.036243467926479;
      3:       atan_deg = 7.125016348901798;
      4:       atan_deg = 3.5763343749973511;
      5:       atan_deg = 1.7899106082460694;
      6:       atan_deg = 0.8951737102110744;
      7:       atan_deg = 0.4476141708605531;
      8:       atan_deg = 0.2238105003685381;
      9:       atan_deg = 0.1119056770662069;
      10:      atan_deg = 0.0559528918938037;
      11:      atan_deg = 0.0279764526170037;
      12:      atan_deg = 0.0139882271422650;
      13:      atan_deg = 0.0069941136753529;
      14:      atan_deg = 0.0034970568507040;
      15:      atan_deg = 0.0017485284269804;
      16:      atan_deg = 0.0008742642136938;
      17:      atan_deg = 0.0004371321068723;
      18:      atan_deg = 0.0002185660534393;
      19:      atan_deg = 0.0001092830267201;
      20:      atan_deg = 0.0000546415133601;
      21:      atan_deg = 0.0000273207566800;
      22:      atan_deg = 0.0000136603783400;
      23:      atan_deg = 0.0000068301891700;
      default: atan_deg = 0.0;
    endcase
  endfunction

  // Constant angle table. It is padded to 32 entries so the 5-bit counter
  // indexes it without a range hole.
  logic signed [AW-1:0] atan_tab [32];
  for (genvar g = 0; g < 32; g++) begin : g_atan
    localparam real SCALED = $floor(atan_deg(g) * (2.0 ** FRAC) + 0.5);
    assign atan_tab[g] = AW'(longint'(SCALED));
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [4:0]           iter_cnt;
  logic                 last_iter, accept, finish, busy_c;
  logic                 done_r, zero_r;
  logic signed [XW-1:0] x_r, y_r, x_ext, y_ext;
  logic signed [XW-1:0] x_cap, y_cap, x_sh, y_sh, x_nxt, y_nxt;
  logic signed [AW-1:0] z_r, z_cap, z_nxt, angle_r;
  logic        [XW-1:0] mag_r;

  assign x_ext     = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
  assign y_ext     = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
  assign last_iter = (iter_cnt == 5'(ITER - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: start is only looked at in IDLE; RUN ends on the last iteration.
  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy indication, operand capture strobe, completion strobe.
  always_comb begin
    busy_c = (state == RUN);
    accept = (state == IDLE) && bus.start;
    finish = (state == RUN) && last_iter;
  end

  // Pre-rotation: fold the left half-plane into x >= 0 by a +/-90 degree turn.
  always_comb begin
    x_cap = x_ext;
    y_cap = y_ext;
    z_cap = '0;
    if (x_ext[XW-1]) begin
      if (!y_ext[XW-1]) begin
        x_cap = y_ext;
        y_cap = -x_ext;
        z_cap = Z_90;
      end else begin
        x_cap = -y_ext;
        y_cap = x_ext;
        z_cap = -Z_90;
      end
    end
  end

  // One vectoring micro-rotation that drives y toward zero.
  always_comb begin
    x_sh = x_r >>> iter_cnt;
    y_sh = y_r >>> iter_cnt;
    if (!y_r[XW-1]) begin
      x_nxt = x_r + y_sh;
      y_nxt = y_r - x_sh;
      z_nxt = z_r + atan_tab[iter_cnt];
    end else begin
      x_nxt = x_r - y_sh;
      y_nxt = y_r + x_sh;
      z_nxt = z_r - atan_tab[iter_cnt];
    end
  end

  // Datapath: capture on accept, iterate in RUN, publish results on the last iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      iter_cnt <= '0;
      zero_r   <= 1'b0;
      angle_r  <= '0;
      mag_r    <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        x_r      <= x_cap;
        y_r      <= y_cap;
        z_r      <= z_cap;
        iter_cnt <= '0;
        // With y stuck at zero the iterations would still add up the whole
        // table, so the origin is flagged and reported as 0 degrees.
        zero_r   <= (bus.x_in == '0) && (bus.y_in == '0);
      end else if (busy_c) begin
        x_r      <= x_nxt;
        y_r      <= y_nxt;
        z_r      <= z_nxt;
        iter_cnt <= iter_cnt + 5'd1;
        if (finish) begin
          angle_r <= zero_r ? '0 : z_nxt;
          mag_r   <= x_nxt;
          done_r  <= 1'b1;
        end
      end
    end
  end

  assign bus.busy  = busy_c;
  assign bus.done  = done_r;
  assign bus.angle = angle_r;
  assign bus.mag   = mag_r;

endmodule

// File: tb/tb_cordic_atan2_seq.sv
// Self-checking bench for cordic_atan2_seq. Expected angles and magnitudes
// come from ideal floating-point atan2/hypot. Tolerances allow for the CORDIC
// residual angle and for integer input quantisation.
module tb_cordic_atan2_seq;
  localparam int  WIDTH   = 32;
  localparam int  AW      = 32;
  localparam int  ITER    = 16;
  localparam real RAD2DEG = 57.29577951308232;
  localparam real LSB_DEG = 1.0 / (2.0 ** (AW - 10));
  localparam int  IMAX    = 2147483647;
  localparam int  IMIN    = -2147483647 - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_atan2_seq_if #(.WIDTH(WIDTH), .AW(AW)) bus   ();
  cordic_atan2_seq_if #(.WIDTH(WIDTH), .AW(AW)) bus8  ();
  cordic_atan2_seq_if #(.WIDTH(WIDTH), .AW(AW)) bus24 ();

  cordic_atan2_seq #(.WIDTH(WIDTH), .AW(AW), .ITER(ITER)) dut   (.clk(clk), .rst(rst), .bus(bus));
  cordic_atan2_seq #(.WIDTH(WIDTH), .AW(AW), .ITER(8))    dut8  (.clk(clk), .rst(rst), .bus(bus8));
  cordic_atan2_seq #(.WIDTH(WIDTH), .AW(AW), .ITER(24))   dut24 (.clk(clk), .rst(rst), .bus(bus24));

  typedef struct { int x; int y; real deg; } vec_t;
  typedef struct { string name; real deg; real mag; bit exact; } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic real kgain(input int iter);
    real k = 1.0;
    for (int i = 0; i < iter; i++) k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
    return k;
  endfunction

  function automatic real ideal_mag(input int x, input int y, input int iter);
    return kgain(iter) * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
  endfunction

  function automatic real ang_tol(input int iter, input real m);
    return RAD2DEG * $atan(2.0 ** (-(iter - 1))) + 4.0 * RAD2DEG / m + 1.0e-5;
  endfunction

  function automatic real mag_tol(input int iter, input real m);
    return real'(iter) + 4.0 + m * (1.0 - $cos($atan(2.0 ** (-(iter - 1))))) + 1.0e-8 * m;
  endfunction

  function automatic real to_deg(input logic signed [AW-1:0] a);
    return real'(a) * LSB_DEG;
  endfunction

  task automatic check(input string name, input real got, input real want, input real tol);
    checks++;
    if ((got - want) > tol || (want - got) > tol) begin
      errors++;
      $display("FAIL %s: got %0.6f, want %0.6f (tol %0.6f)", name, got, want, tol);
    end
  endtask

  function automatic void push_exp(input string name, input int x, input int y, input real deg);
    exp_t e;
    e.name  = name;
    e.deg   = deg;
    e.exact = (x == 0) && (y == 0);
    e.mag   = e.exact ? 0.0 : ideal_mag(x, y, ITER);
    sb.push_back(e);
  endfunction

  // Scoreboard monitor: every done pulse of the main instance retires one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at %0t: got done=1, want no pending result", $time);
      end else begin
        e = sb.pop_front();
        if (e.exact) begin
          check({e.name, "_angle"}, to_deg(bus.angle), 0.0, 0.0);
          check({e.name, "_mag"}, real'(bus.mag), 0.0, 0.0);
        end else begin
          check({e.name, "_angle"}, to_deg(bus.angle), e.deg, ang_tol(ITER, e.mag));
          check({e.name, "_mag"}, real'(bus.mag), e.mag, mag_tol(ITER, e.mag));
        end
      end
    end
  end

  // One start pulse. Checks latency and that busy covers exactly the run.
  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    bus.x_in  = v.x;
    bus.y_in  = v.y;
    bus.start = 1'b1;
    push_exp(name, v.x, v.y, v.deg);
    @(negedge clk);
    bus.start = 1'b0;
    cyc     = 1;
    busy_ok = 1'b1;
    while (!bus.done && cyc < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, real'(cyc), real'(ITER + 1), 0.0);
    check({name, "_busy_window"}, real'(busy_ok && !bus.busy), 1.0, 0.0);
  endtask

  initial begin
    vec_t vt [10];
    int   cyc, n, last, nd, first, d8, d24;
    real  a8, a24, m8, m24;

    vt[0] = '{x: 1000,    y: 1000,    deg: 45.0};
    vt[1] = '{x: 1000,    y: 0,       deg: 0.0};
    vt[2] = '{x: 0,       y: 1000,    deg: 90.0};
    vt[3] = '{x: -1000,   y: 1000,    deg: 135.0};
    vt[4] = '{x: -1000,   y: -1000,   deg: -135.0};
    vt[5] = '{x: 0,       y: -1000,   deg: -90.0};
    vt[6] = '{x: -1000,   y: 0,       deg: 180.0};
    vt[7] = '{x: IMIN,    y: IMIN,    deg: -135.0};
    vt[8] = '{x: 0,       y: 0,       deg: 0.0};
    vt[9] = '{x: IMAX,    y: IMIN,    deg: RAD2DEG * $atan2(-2147483648.0, 2147483647.0)};

    bus.start   = 1'b0; bus.x_in   = '0; bus.y_in   = '0;
    bus8.start  = 1'b0; bus8.x_in  = '0; bus8.y_in  = '0;
    bus24.start = 1'b0; bus24.x_in = '0; bus24.y_in = '0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy",  real'(bus.busy), 0.0, 0.0);
    check("reset_done",  real'(bus.done), 0.0, 0.0);
    check("reset_angle", to_deg(bus.angle), 0.0, 0.0);
    check("reset_mag",   real'(bus.mag), 0.0, 0.0);

    // Vector table: quadrants, axes, extremes, origin.
    for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // start held high: one accepted request per ITER+1 cycles.
    @(negedge clk);
    bus.x_in  = vt[0].x;
    bus.y_in  = vt[0].y;
    bus.start = 1'b1;
    push_exp("held0", vt[0].x, vt[0].y, vt[0].deg);
    n = 0; cyc = 0; last = 0;
    while (n < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        n++;
        if (n > 1) check($sformatf("held_spacing%0d", n), real'(cyc - last), real'(ITER + 1), 0.0);
        last = cyc;
        if (n < 3) begin
          bus.x_in = vt[3 * n].x;
          bus.y_in = vt[3 * n].y;
          push_exp($sformatf("held%0d", n), vt[3 * n].x, vt[3 * n].y, vt[3 * n].deg);
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    check("held_count", real'(n), 3.0, 0.0);
    nd = 0;
    repeat (2 * (ITER + 1)) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("held_no_extra_done", real'(nd), 0.0, 0.0);

    // start pulsed mid-run with different operands: ignored.
    @(negedge clk);
    bus.x_in  = vt[4].x;
    bus.y_in  = vt[4].y;
    bus.start = 1'b1;
    push_exp("midrun", vt[4].x, vt[4].y, vt[4].deg);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; nd = 0; first = 0;
    while (cyc < 45) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        bus.start = 1'b1;
        bus.x_in  = 5;
        bus.y_in  = -7;
      end
      if (cyc == 6) begin
        bus.start = 1'b0;
        bus.x_in  = 321;
        bus.y_in  = 654;
      end
      if (bus.done) begin
        nd++;
        if (first == 0) first = cyc;
      end
    end
    check("midrun_done_count", real'(nd), 1.0, 0.0);
    check("midrun_latency", real'(first), real'(ITER + 1), 0.0);

    // Reset on the edge that would perform iteration 5.
    @(negedge clk);
    bus.x_in  = vt[2].x;
    bus.y_in  = vt[2].y;
    bus.start = 1'b1;
    push_exp("aborted", vt[2].x, vt[2].y, vt[2].deg);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midreset_busy",  real'(bus.busy), 0.0, 0.0);
    check("midreset_done",  real'(bus.done), 0.0, 0.0);
    check("midreset_angle", to_deg(bus.angle), 0.0, 0.0);
    check("midreset_mag",   real'(bus.mag), 0.0, 0.0);
    rst = 1'b0;
    nd = 0;
    repeat (2 * (ITER + 1)) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("midreset_no_done", real'(nd), 0.0, 0.0);
    run_vec(vt[1], "after_reset");

    // ITER=8 and ITER=24 builds on a scaled (3,4) pair.
    @(negedge clk);
    bus8.x_in  = 3 <<< 24; bus8.y_in  = 4 <<< 24; bus8.start  = 1'b1;
    bus24.x_in = 3 <<< 24; bus24.y_in = 4 <<< 24; bus24.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0; bus24.start = 1'b0;
    cyc = 1; d8 = 0; d24 = 0;
    a8 = 0.0; a24 = 0.0; m8 = 0.0; m24 = 0.0;
    while ((d8 == 0 || d24 == 0) && cyc < 60) begin
      if (bus8.done && d8 == 0) begin
        d8 = cyc; a8 = to_deg(bus8.angle); m8 = real'(bus8.mag);
      end
      if (bus24.done && d24 == 0) begin
        d24 = cyc; a24 = to_deg(bus24.angle); m24 = real'(bus24.mag);
      end
      @(negedge clk);
      cyc++;
    end
    check("iter8_latency",  real'(d8),  9.0,  0.0);
    check("iter24_latency", real'(d24), 25.0, 0.0);
    check("iter8_angle",  a8,  53.13010235415598,
          ang_tol(8,  ideal_mag(3 <<< 24, 4 <<< 24, 8)));
    check("iter24_angle", a24, 53.13010235415598,
          ang_tol(24, ideal_mag(3 <<< 24, 4 <<< 24, 24)));
    check("iter8_mag",  m8,  ideal_mag(3 <<< 24, 4 <<< 24, 8),
          mag_tol(8,  ideal_mag(3 <<< 24, 4 <<< 24, 8)));
    check("iter24_mag", m24, ideal_mag(3 <<< 24, 4 <<< 24, 24),
          mag_tol(24, ideal_mag(3 <<< 24, 4 <<< 24, 24)));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", real'(sb.size()), 0.0, 0.0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
